hazard_stall_unit: RTL and testbench

Pipeline control block for the RV32IM 5-stage core. It sits beside the forwarding unit and covers the hazards forwarding cannot resolve:
- load-use in ID against a load in EXE
- multi-cycle MUL/DIV occupancy of EXE
- taken-branch squash
- instruction/data memory busywait

It drives hold, flush and bubble controls for PC, IF/ID, ID/EX and EX/MEM, and keeps a stall-cycle performance counter.

---
 rtl/hazard_stall_unit_pkg.sv | 15 +
 rtl/hazard_stall_unit_if.sv | 47 ++++
 rtl/hazard_stall_unit_muldiv_occupancy_counter.sv | 41 ++++
 rtl/hazard_stall_unit.sv | 150 +++++++++++++++
 tb/tb_hazard_stall_unit.sv | 321 ++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/hazard_stall_unit_pkg.sv
// Shared encodings for the hazard/stall control block.
// Contents:
//   STORE_OPCODE, R_TYPE_OPCODE : RV32 major opcodes referenced by the hazard logic and bench
//   state_t                     : controller state (RUN / MD_BUSY)
package hazard_stall_unit_pkg;

  localparam logic [6:0] STORE_OPCODE  = 7'b0100011;
  localparam logic [6:0] R_TYPE_OPCODE = 7'b0110011;

  typedef enum logic {
    RUN     = 1'b0,
    MD_BUSY = 1'b1
  } state_t;

endpackage : hazard_stall_unit_pkg

// File: rtl/hazard_stall_unit_if.sv
// Pipeline <-> hazard/stall unit signal bundle.
// master : pipeline side, drives ID/EXE/memory status, receives stall controls
// slave  : hazard unit side, receives status, drives stall controls and STALL_CYCLES
interface hazard_stall_unit_if;

  // Pipeline status
  logic [4:0]  ID_ADDR1;
  logic [4:0]  ID_ADDR2;
  logic        ID_USES_RS1;
  logic        ID_USES_RS2;
  logic [6:0]  ID_OPCODE;
  logic [4:0]  EXE_ADDR;
  logic        EXE_MEM_READ;
  logic        EXE_MULDIV_START;
  logic        EXE_IS_DIV;
  logic        BRANCH_TAKEN;
  logic        INS_MEM_BUSYWAIT;
  logic        DATA_MEM_BUSYWAIT;

  // Stall / flush controls
  logic        PC_HOLD;
  logic        IF_ID_HOLD;
  logic        IF_ID_FLUSH;
  logic        ID_EX_HOLD;
  logic        ID_EX_BUBBLE;
  logic        EX_MEM_HOLD;
  logic        EX_MEM_BUBBLE;
  logic        MULDIV_BUSY;
  logic [31:0] STALL_CYCLES;

  modport master (
    output ID_ADDR1, ID_ADDR2, ID_USES_RS1, ID_USES_RS2, ID_OPCODE,
           EXE_ADDR, EXE_MEM_READ, EXE_MULDIV_START, EXE_IS_DIV,
           BRANCH_TAKEN, INS_MEM_BUSYWAIT, DATA_MEM_BUSYWAIT,
    input  PC_HOLD, IF_ID_HOLD, IF_ID_FLUSH, ID_EX_HOLD, ID_EX_BUBBLE,
           EX_MEM_HOLD, EX_MEM_BUBBLE, MULDIV_BUSY, STALL_CYCLES
  );

  modport slave (
    input  ID_ADDR1, ID_ADDR2, ID_USES_RS1, ID_USES_RS2, ID_OPCODE,
           EXE_ADDR, EXE_MEM_READ, EXE_MULDIV_START, EXE_IS_DIV,
           BRANCH_TAKEN, INS_MEM_BUSYWAIT, DATA_MEM_BUSYWAIT,
    output PC_HOLD, IF_ID_HOLD, IF_ID_FLUSH, ID_EX_HOLD, ID_EX_BUBBLE,
           EX_MEM_HOLD, EX_MEM_BUBBLE, MULDIV_BUSY, STALL_CYCLES
  );

endinterface : hazard_stall_unit_if

// File: rtl/hazard_stall_unit_muldiv_occupancy_counter.sv
// Down-counter tracking the remaining EXE occupancy of a multi-cycle M-extension op.
// Ports:
//   CLK, RESET : clock, synchronous active-high reset (clears the count)
//   en         : 0 freezes the count (data-memory stall)
//   load       : load load_val (takes precedence over decrement)
//   load_val   : L-2 for the starting operation
//   cnt        : current count
//   zero       : cnt == 0
module muldiv_occupancy_counter #(
  parameter int CNT_W = 6
) (
  input  logic             CLK,
  input  logic             RESET,
  input  logic             en,
  input  logic             load,
  input  logic [CNT_W-1:0] load_val,
  output logic [CNT_W-1:0] cnt,
  output logic             zero
);

  logic [CNT_W-1:0] cnt_r;

  // Count register: load, saturating decrement, or freeze
  always_ff @(posedge CLK) begin
    if (RESET) begin
      cnt_r <= {CNT_W{1'b0}};
    end else if (!en) begin
      cnt_r <= cnt_r;
    end else if (load) begin
      cnt_r <= load_val;
    end else if (cnt_r != {CNT_W{1'b0}}) begin
      cnt_r <= cnt_r - {{(CNT_W-1){1'b0}}, 1'b1};
    end else begin
      cnt_r <= cnt_r;
    end
  end

  assign cnt  = cnt_r;
  assign zero = (cnt_r == {CNT_W{1'b0}});

endmodule : muldiv_occupancy_counter

// File: rtl/hazard_stall_unit.sv
// Pipeline hazard/stall controller for the RV32IM 5-stage core.
// Resolves load-use, multi-cycle MUL/DIV occupancy, taken-branch squash and
// instruction/data memory busywait; counts cycles in which the PC is held.
// Ports:
//   CLK   : system clock, rising edge
//   RESET : synchronous active-high reset
//   bus   : hazard_stall_unit_if.slave (pipeline status in, stall controls out)
// Control outputs are Mealy (state, count and current inputs); state, count and
// STALL_CYCLES are registered.
module hazard_stall_unit
  import hazard_stall_unit_pkg::*;
#(
  parameter int MUL_CYCLES = 2,
  parameter int DIV_CYCLES = 32,
  parameter int CNT_W      = 6
) (
  input  logic                 CLK,
  input  logic                 RESET,
  hazard_stall_unit_if.slave   bus
);

  // Occupancy count loaded at start is L-2: the start cycle and the final
  // release cycle are not counted.
  localparam logic [CNT_W-1:0] MUL_LOAD = CNT_W'(MUL_CYCLES - 2);
  localparam logic [CNT_W-1:0] DIV_LOAD = CNT_W'(DIV_CYCLES - 2);
  localparam logic             MUL_LONG = (MUL_CYCLES > 1);
  localparam logic             DIV_LONG = (DIV_CYCLES > 1);

  state_t            state_r;
  logic [31:0]       stall_cycles_r;
  logic [CNT_W-1:0]  cnt_s;
  logic              cnt_zero_s;
  logic              load_use_s;
  logic              start_long_s;
  logic              run_start_s;
  logic              md_stall_s;
  logic [CNT_W-1:0]  load_val_s;

  logic pc_hold_s;
  logic if_id_hold_s;
  logic if_id_flush_s;
  logic id_ex_hold_s;
  logic id_ex_bubble_s;
  logic ex_mem_hold_s;
  logic ex_mem_bubble_s;

  // Store data (rs2) is forwarded at MEM, so it never causes a load-use stall
  assign load_use_s = bus.EXE_MEM_READ && (bus.EXE_ADDR != 5'd0) &&
                      ((bus.ID_USES_RS1 && (bus.ID_ADDR1 == bus.EXE_ADDR)) ||
                       (bus.ID_USES_RS2 && (bus.ID_ADDR2 == bus.EXE_ADDR) &&
                        (bus.ID_OPCODE != STORE_OPCODE)));

  assign start_long_s = bus.EXE_MULDIV_START && (bus.EXE_IS_DIV ? DIV_LONG : MUL_LONG);
  assign load_val_s   = bus.EXE_IS_DIV ? DIV_LOAD : MUL_LOAD;

  // A taken branch in RUN squashes the would-be start
  assign run_start_s = (state_r == RUN) && !bus.BRANCH_TAKEN && start_long_s;
  assign md_stall_s  = run_start_s || ((state_r == MD_BUSY) && !cnt_zero_s);

  muldiv_occupancy_counter #(
    .CNT_W (CNT_W)
  ) u_occ_cnt (
    .CLK      (CLK),
    .RESET    (RESET),
    .en       (!bus.DATA_MEM_BUSYWAIT),
    .load     (run_start_s),
    .load_val (load_val_s),
    .cnt      (cnt_s),
    .zero     (cnt_zero_s)
  );

  // Stall/flush control decode in priority order
  always_comb begin
    pc_hold_s       = 1'b0;
    if_id_hold_s    = 1'b0;
    if_id_flush_s   = 1'b0;
    id_ex_hold_s    = 1'b0;
    id_ex_bubble_s  = 1'b0;
    ex_mem_hold_s   = 1'b0;
    ex_mem_bubble_s = 1'b0;
    if (RESET) begin
      pc_hold_s = 1'b0;
    end else if (bus.DATA_MEM_BUSYWAIT) begin
      pc_hold_s     = 1'b1;
      if_id_hold_s  = 1'b1;
      id_ex_hold_s  = 1'b1;
      ex_mem_hold_s = 1'b1;
    end else if ((state_r == RUN) && bus.BRANCH_TAKEN) begin
      if_id_flush_s  = 1'b1;
      id_ex_bubble_s = 1'b1;
    end else begin
      if (md_stall_s) begin
        pc_hold_s       = 1'b1;
        if_id_hold_s    = 1'b1;
        id_ex_hold_s    = 1'b1;
        ex_mem_bubble_s = 1'b1;
      end else if (load_use_s) begin
        pc_hold_s      = 1'b1;
        if_id_hold_s   = 1'b1;
        id_ex_bubble_s = 1'b1;
      end else begin
        pc_hold_s = 1'b0;
      end
      // A held IF/ID already blocks the stale fetch, so hold beats flush
      if (bus.INS_MEM_BUSYWAIT) begin
        pc_hold_s     = 1'b1;
        if_id_flush_s = !if_id_hold_s;
      end else begin
        if_id_flush_s = 1'b0;
      end
    end
  end

  // Controller state: frozen while data memory is busy
  always_ff @(posedge CLK) begin
    if (RESET) begin
      state_r <= RUN;
    end else if (bus.DATA_MEM_BUSYWAIT) begin
      state_r <= state_r;
    end else begin
      case (state_r)
        RUN:     state_r <= run_start_s ? MD_BUSY : RUN;
        MD_BUSY: state_r <= cnt_zero_s ? RUN : MD_BUSY;
        default: state_r <= RUN;
      endcase
    end
  end

  // Stall-cycle performance counter, wraps naturally at 2^32
  always_ff @(posedge CLK) begin
    if (RESET) begin
      stall_cycles_r <= 32'd0;
    end else if (pc_hold_s) begin
      stall_cycles_r <= stall_cycles_r + 32'd1;
    end else begin
      stall_cycles_r <= stall_cycles_r;
    end
  end

  assign bus.PC_HOLD       = pc_hold_s;
  assign bus.IF_ID_HOLD    = if_id_hold_s;
  assign bus.IF_ID_FLUSH   = if_id_flush_s;
  assign bus.ID_EX_HOLD    = id_ex_hold_s;
  assign bus.ID_EX_BUBBLE  = id_ex_bubble_s;
  assign bus.EX_MEM_HOLD   = ex_mem_hold_s;
  assign bus.EX_MEM_BUBBLE = ex_mem_bubble_s;
  assign bus.MULDIV_BUSY   = (state_r == MD_BUSY);
  assign bus.STALL_CYCLES  = stall_cycles_r;

endmodule : hazard_stall_unit

// File: tb/tb_hazard_stall_unit.sv
// Directed self-checking bench for hazard_stall_unit (MUL_CYCLES=2, DIV_CYCLES=32).
// Control vector order: {PC_HOLD, IF_ID_HOLD, IF_ID_FLUSH, ID_EX_HOLD,
//                        ID_EX_BUBBLE, EX_MEM_HOLD, EX_MEM_BUBBLE}
module tb_hazard_stall_unit;
  import hazard_stall_unit_pkg::*;

  localparam logic [6:0] V_NONE = 7'b0000000;
  localparam logic [6:0] V_LU   = 7'b1100100;
  localparam logic [6:0] V_MD   = 7'b1101001;
  localparam logic [6:0] V_DMB  = 7'b1101010;
  localparam logic [6:0] V_BR   = 7'b0010100;
  localparam logic [6:0] V_IMB  = 7'b1010000;

  logic clk;
  logic rst;
  int   pass_cnt;
  int   total_cnt;
  logic [31:0] base;

  hazard_stall_unit_if hs_if ();

  hazard_stall_unit #(
    .MUL_CYCLES (2),
    .DIV_CYCLES (32),
    .CNT_W      (6)
  ) dut (
    .CLK   (clk),
    .RESET (rst),
    .bus   (hs_if)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [6:0] ctl_vec();
    return {hs_if.PC_HOLD, hs_if.IF_ID_HOLD, hs_if.IF_ID_FLUSH, hs_if.ID_EX_HOLD,
            hs_if.ID_EX_BUBBLE, hs_if.EX_MEM_HOLD, hs_if.EX_MEM_BUBBLE};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_inputs();
    hs_if.ID_ADDR1          = 5'd0;
    hs_if.ID_ADDR2          = 5'd0;
    hs_if.ID_USES_RS1       = 1'b0;
    hs_if.ID_USES_RS2       = 1'b0;
    hs_if.ID_OPCODE         = R_TYPE_OPCODE;
    hs_if.EXE_ADDR          = 5'd0;
    hs_if.EXE_MEM_READ      = 1'b0;
    hs_if.EXE_MULDIV_START  = 1'b0;
    hs_if.EXE_IS_DIV        = 1'b0;
    hs_if.BRANCH_TAKEN      = 1'b0;
    hs_if.INS_MEM_BUSYWAIT  = 1'b0;
    hs_if.DATA_MEM_BUSYWAIT = 1'b0;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    clear_inputs();
    tick();
    rst = 1'b0;
    #1;
  endtask

  // lw x1 in EXE; add x3,x2,x1 in ID
  task automatic set_load_use();
    hs_if.EXE_MEM_READ = 1'b1;
    hs_if.EXE_ADDR     = 5'd1;
    hs_if.ID_ADDR1     = 5'd2;
    hs_if.ID_ADDR2     = 5'd1;
    hs_if.ID_USES_RS1  = 1'b1;
    hs_if.ID_USES_RS2  = 1'b1;
    hs_if.ID_OPCODE    = R_TYPE_OPCODE;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    set_load_use();
    hs_if.DATA_MEM_BUSYWAIT = 1'b1;
    hs_if.INS_MEM_BUSYWAIT  = 1'b1;
    #1;
    total_cnt++;
    if (ctl_vec() !== V_NONE) $display("FAIL reset_ctl: got %b want %b", ctl_vec(), V_NONE);
    else pass_cnt++;
    tick();
    rst = 1'b0;
    clear_inputs();
    #1;
    total_cnt++;
    if (hs_if.STALL_CYCLES !== 32'd0 || hs_if.MULDIV_BUSY !== 1'b0)
      $display("FAIL reset_state: stall=%0d busy=%b want 0/0", hs_if.STALL_CYCLES, hs_if.MULDIV_BUSY);
    else pass_cnt++;
    total_cnt++;
    if (ctl_vec() !== V_NONE) $display("FAIL idle_ctl: got %b want %b", ctl_vec(), V_NONE);
    else pass_cnt++;
  endtask

  task automatic test_load_use();
    do_reset();
    set_load_use();
    #1;
    total_cnt++;
    if (ctl_vec() !== V_LU) $display("FAIL lu_stall: got %b want %b", ctl_vec(), V_LU);
    else pass_cnt++;
    tick();
    // bubble has cleared EXE
    hs_if.EXE_MEM_READ = 1'b0;
    hs_if.EXE_ADDR     = 5'd0;
    #1;
    total_cnt++;
    if (ctl_vec() !== V_NONE) $display("FAIL lu_release: got %b want %b", ctl_vec(), V_NONE);
    else pass_cnt++;
    total_cnt++;
    if (hs_if.STALL_CYCLES !== 32'd1) $display("FAIL lu_stall_cnt: got %0d want 1", hs_if.STALL_CYCLES);
    else pass_cnt++;
  endtask

  task automatic test_lu_exempt();
    do_reset();
    // sw x1,8(x3): rs2 match is exempt
    hs_if.EXE_MEM_READ = 1'b1;
    hs_if.EXE_ADDR     = 5'd1;
    hs_if.ID_OPCODE    = STORE_OPCODE;
    hs_if.ID_ADDR1     = 5'd3;
    hs_if.ID_ADDR2     = 5'd1;
    hs_if.ID_USES_RS1  = 1'b1;
    hs_if.ID_USES_RS2  = 1'b1;
    #1;
    total_cnt++;
    if (ctl_vec() !== V_NONE) $display("FAIL store_rs2_exempt: got %b want %b", ctl_vec(), V_NONE);
    else pass_cnt++;
    // store base register still hazards
    hs_if.ID_ADDR1 = 5'd1;
    hs_if.ID_ADDR2 = 5'd4;
    #1;
    total_cnt++;
    if (ctl_vec() !== V_LU) $display("FAIL store_rs1_lu: got %b want %b", ctl_vec(), V_LU);
    else pass_cnt++;
    // x0 destination never hazards
    hs_if.ID_OPCODE = R_TYPE_OPCODE;
    hs_if.EXE_ADDR  = 5'd0;
    hs_if.ID_ADDR1  = 5'd0;
    hs_if.ID_ADDR2  = 5'd0;
    #1;
    total_cnt++;
    if (ctl_vec() !== V_NONE) $display("FAIL x0_exempt: got %b want %b", ctl_vec(), V_NONE);
    else pass_cnt++;
    // matching register that ID does not read
    hs_if.EXE_ADDR    = 5'd7;
    hs_if.ID_ADDR1    = 5'd7;
    hs_if.ID_USES_RS1 = 1'b0;
    hs_if.ID_USES_RS2 = 1'b0;
    #1;
    total_cnt++;
    if (ctl_vec() !== V_NONE) $display("FAIL unused_rs: got %b want %b", ctl_vec(), V_NONE);
    else pass_cnt++;
    tick();
    total_cnt++;
    if (hs_if.STALL_CYCLES !== 32'd0) $display("FAIL exempt_stall_cnt: got %0d want 0", hs_if.STALL_CYCLES);
    else pass_cnt++;
  endtask

  task automatic test_div();
    do_reset();
    hs_if.EXE_MULDIV_START = 1'b1;
    hs_if.EXE_IS_DIV       = 1'b1;
    #1;
    total_cnt++;
    if (ctl_vec() !== V_MD) $display("FAIL div_start: got %b want %b", ctl_vec(), V_MD);
    else pass_cnt++;
    tick();
    clear_inputs();
    #1;
    total_cnt++;
    if (hs_if.MULDIV_BUSY !== 1'b1) $display("FAIL div_busy: got %b want 1", hs_if.MULDIV_BUSY);
    else pass_cnt++;
    // cycles 2..31 held, cycle 32 released
    for (int i = 2; i <= 32; i++) begin
      total_cnt++;
      if (ctl_vec() !== ((i <= 31) ? V_MD : V_NONE))
        $display("FAIL div_cycle%0d: got %b want %b", i, ctl_vec(), (i <= 31) ? V_MD : V_NONE);
      else pass_cnt++;
      tick();
    end
    total_cnt++;
    if (hs_if.MULDIV_BUSY !== 1'b0 || ctl_vec() !== V_NONE)
      $display("FAIL div_done: busy=%b ctl=%b want 0/%b", hs_if.MULDIV_BUSY, ctl_vec(), V_NONE);
    else pass_cnt++;
    total_cnt++;
    if (hs_if.STALL_CYCLES !== 32'd31) $display("FAIL div_stall_cnt: got %0d want 31", hs_if.STALL_CYCLES);
    else pass_cnt++;
  endtask

  task automatic test_mul();
    do_reset();
    hs_if.EXE_MULDIV_START = 1'b1;
    hs_if.EXE_IS_DIV       = 1'b0;
    #1;
    total_cnt++;
    if (ctl_vec() !== V_MD) $display("FAIL mul_start: got %b want %b", ctl_vec(), V_MD);
    else pass_cnt++;
    tick();
    clear_inputs();
    #1;
    total_cnt++;
    if (ctl_vec() !== V_NONE) $display("FAIL mul_release: got %b want %b", ctl_vec(), V_NONE);
    else pass_cnt++;
    tick();
    total_cnt++;
    if (hs_if.MULDIV_BUSY !== 1'b0 || hs_if.STALL_CYCLES !== 32'd1)
      $display("FAIL mul_done: busy=%b stall=%0d want 0/1", hs_if.MULDIV_BUSY, hs_if.STALL_CYCLES);
    else pass_cnt++;
  endtask

  task automatic test_dmb_mid_div();
    do_reset();
    hs_if.EXE_MULDIV_START = 1'b1;
    hs_if.EXE_IS_DIV       = 1'b1;
    tick();
    clear_inputs();
    // cycles 2..21 held; cycle 22 sees count 10
    for (int i = 2; i <= 21; i++) tick();
    hs_if.DATA_MEM_BUSYWAIT = 1'b1;
    for (int i = 0; i < 3; i++) begin
      #1;
      total_cnt++;
      if (ctl_vec() !== V_DMB) $display("FAIL dmb_hold%0d: got %b want %b", i, ctl_vec(), V_DMB);
      else pass_cnt++;
      tick();
    end
    hs_if.DATA_MEM_BUSYWAIT = 1'b0;
    #1;
    // count frozen at 10: ten more held cycles, then release
    for (int j = 0; j <= 10; j++) begin
      total_cnt++;
      if (ctl_vec() !== ((j < 10) ? V_MD : V_NONE))
        $display("FAIL dmb_resume%0d: got %b want %b", j, ctl_vec(), (j < 10) ? V_MD : V_NONE);
      else pass_cnt++;
      tick();
    end
    total_cnt++;
    if (hs_if.STALL_CYCLES !== 32'd34) $display("FAIL dmb_stall_cnt: got %0d want 34", hs_if.STALL_CYCLES);
    else pass_cnt++;
  endtask

  task automatic test_branch();
    do_reset();
    set_load_use();
    hs_if.INS_MEM_BUSYWAIT = 1'b1;
    hs_if.BRANCH_TAKEN     = 1'b1;
    #1;
    total_cnt++;
    if (ctl_vec() !== V_BR) $display("FAIL branch_priority: got %b want %b", ctl_vec(), V_BR);
    else pass_cnt++;
    hs_if.BRANCH_TAKEN = 1'b0;
    #1;
    total_cnt++;
    if (ctl_vec() !== V_LU) $display("FAIL lu_over_imb: got %b want %b", ctl_vec(), V_LU);
    else pass_cnt++;
    clear_inputs();
    hs_if.INS_MEM_BUSYWAIT = 1'b1;
    #1;
    total_cnt++;
    if (ctl_vec() !== V_IMB) $display("FAIL imb_only: got %b want %b", ctl_vec(), V_IMB);
    else pass_cnt++;
    base = hs_if.STALL_CYCLES;
    tick();
    total_cnt++;
    if (hs_if.STALL_CYCLES !== base + 32'd1) $display("FAIL imb_stall_cnt: got %0d want %0d", hs_if.STALL_CYCLES, base + 32'd1);
    else pass_cnt++;
  endtask

  task automatic test_reset_mid_div();
    do_reset();
    hs_if.EXE_MULDIV_START = 1'b1;
    hs_if.EXE_IS_DIV       = 1'b1;
    tick();
    clear_inputs();
    // cycle 27 sees count 5
    for (int i = 2; i <= 26; i++) tick();
    total_cnt++;
    if (ctl_vec() !== V_MD || hs_if.MULDIV_BUSY !== 1'b1)
      $display("FAIL pre_reset_busy: ctl=%b busy=%b want %b/1", ctl_vec(), hs_if.MULDIV_BUSY, V_MD);
    else pass_cnt++;
    rst = 1'b1;
    #1;
    total_cnt++;
    if (ctl_vec() !== V_NONE) $display("FAIL reset_mid_ctl: got %b want %b", ctl_vec(), V_NONE);
    else pass_cnt++;
    tick();
    rst = 1'b0;
    #1;
    total_cnt++;
    if (hs_if.MULDIV_BUSY !== 1'b0 || hs_if.STALL_CYCLES !== 32'd0 || ctl_vec() !== V_NONE)
      $display("FAIL reset_abort: busy=%b stall=%0d ctl=%b want 0/0/%b",
               hs_if.MULDIV_BUSY, hs_if.STALL_CYCLES, ctl_vec(), V_NONE);
    else pass_cnt++;
  endtask

  initial begin
    pass_cnt  = 0;
    total_cnt = 0;
    rst = 1'b1;
    clear_inputs();
    tick();
    test_reset();
    test_load_use();
    test_lu_exempt();
    test_div();
    test_mul();
    test_dmb_mid_div();
    test_branch();
    test_reset_mid_div();
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule : tb_hazard_stall_unit
